// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        REL_DB
    } kp_state_t;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    localparam logic [3:0] KEY_CLEAR = 4'd11;

    // Index of the lowest-numbered row pulled low; callers ensure at least one is low.
    function automatic logic [1:0] lowest_low(input logic [KP_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = KP_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [KP_COLS-1:0] col_drive(input logic [1:0] c);
        return ~(KP_COLS'(1) << c);
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous keypad rows; resets to all-ones (rows idle high).
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce and a one-cycle newkey pulse per key event.
// Define KEYPAD_AUTOREPEAT_EN to re-emit newkey every REPEAT cycles while a key is held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 5000,
    parameter int DEBOUNCE = 50000
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT   = 2500000
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [KP_ROWS-1:0] row,
    output logic [KP_COLS-1:0] col,
    output logic               newkey,
    output logic [3:0]         keycode
);

    localparam int MAX_SD = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int MAX_P  = (MAX_SD > REPEAT) ? MAX_SD : REPEAT;
`else
    localparam int MAX_P  = MAX_SD;
`endif
    localparam int CW = $clog2(MAX_P);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT - 1);
`endif

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    logic [KP_ROWS-1:0] rs;

    kp_state_t     state, state_n;
    logic [1:0]    c, c_n;
    logic [1:0]    r, r_n;
    logic [CW-1:0] scan_cnt, scan_cnt_n;
    logic [CW-1:0] db_cnt, db_cnt_n;
    logic          newkey_n;
    logic [3:0]    keycode_n;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [CW-1:0] rep_cnt, rep_cnt_n;
`endif

    keypad_sync #(
        .WIDTH(KP_ROWS)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (row),
        .q    (rs)
    );

    // NOTE: every register gets an explicit async reset value; nothing is left to power-up state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= SCAN;
            c        <= 2'd0;
            r        <= 2'd0;
            scan_cnt <= '0;
            db_cnt   <= '0;
            col      <= col_drive(2'd0);
            newkey   <= 1'b0;
            keycode  <= 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt  <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, as the hardware does.
            state    <= state_n;
            c        <= c_n;
            r        <= r_n;
            scan_cnt <= scan_cnt_n;
            db_cnt   <= db_cnt_n;
            col      <= col_drive(c_n);
            newkey   <= newkey_n;
            keycode  <= keycode_n;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt  <= rep_cnt_n;
`endif
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_n    = state;
        c_n        = c;
        r_n        = r;
        scan_cnt_n = scan_cnt;
        db_cnt_n   = db_cnt;
        newkey_n   = 1'b0;
        keycode_n  = keycode;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_n  = rep_cnt;
`endif

        unique case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_n = '0;
                    if (&rs) begin
                        c_n = c + 2'd1;
                    end else begin
                        r_n      = lowest_low(rs);
                        db_cnt_n = '0;
                        state_n  = PRESS_DB;
                    end
                end else begin
                    scan_cnt_n = sat_inc(scan_cnt);
                end
            end

            PRESS_DB: begin
                if (rs[r]) begin
                    c_n        = c + 2'd1;
                    scan_cnt_n = '0;
                    state_n    = SCAN;
                end else if (db_cnt == DB_LAST) begin
                    newkey_n  = 1'b1;
                    keycode_n = {r, c};
                    db_cnt_n  = '0;
                    state_n   = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_cnt_n = '0;
`endif
                end else begin
                    db_cnt_n = sat_inc(db_cnt);
                end
            end

            HELD: begin
                if (rs[r]) begin
                    db_cnt_n  = '0;
                    state_n   = REL_DB;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_cnt_n = '0;
                end else if (rep_cnt == REP_LAST) begin
                    newkey_n  = 1'b1;
                    rep_cnt_n = '0;
                end else begin
                    rep_cnt_n = sat_inc(rep_cnt);
`endif
                end
            end

            REL_DB: begin
                // A low glitch during release drops back to HELD without a new event.
                if (!rs[r]) begin
                    db_cnt_n = '0;
                    state_n  = HELD;
                end else if (db_cnt == DB_LAST) begin
                    c_n        = 2'd0;
                    scan_cnt_n = '0;
                    db_cnt_n   = '0;
                    state_n    = SCAN;
                end else begin
                    db_cnt_n = sat_inc(db_cnt);
                end
            end

            default: state_n = SCAN;
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=8 (REPEAT=16 when autorepeat is built).
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        newkey;
    logic [3:0]  keycode;
    logic [15:0] keys;

    int n_checks = 0;
    int n_err    = 0;

    int   pulses   = 0;
    int   dbl_viol = 0;
    int   kc_viol  = 0;
    logic       prev_nk = 1'b0;
    logic [3:0] prev_kc = 4'h0;

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE(8)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT  (16)
`endif
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .row    (row),
        .col    (col),
        .newkey (newkey),
        .keycode(keycode)
    );

    always #5 clock = ~clock;

    // Keypad matrix: key (r,c) is bit r*4+c; a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int rr = 0; rr < 4; rr++) begin
            row[rr] = ~|(keys[rr*4 +: 4] & ~col);
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            prev_nk <= 1'b0;
            prev_kc <= keycode;
        end else begin
            if (newkey) pulses <= pulses + 1;
            if (newkey && prev_nk) dbl_viol <= dbl_viol + 1;
            if (keycode !== prev_kc && !newkey) kc_viol <= kc_viol + 1;
            prev_nk <= newkey;
            prev_kc <= keycode;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic wait_pulse(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if (newkey) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;
        int rep_offs[$];

        keys  = 16'h0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check("rst_col", col, 4'b1110);
        check("rst_newkey", newkey, 1'b0);
        check("rst_keycode", keycode, 4'h0);
        reset = 1'b0;

        // Scan sequence: each column dwells 4 cycles.
        step(3);  check("scan_c0", col, 4'b1110);
        step(1);  check("scan_c1", col, 4'b1101);
        step(4);  check("scan_c2", col, 4'b1011);
        step(4);  check("scan_c3", col, 4'b0111);
        step(4);  check("scan_wrap", col, 4'b1110);

        // Clean press of row 2 / column 3: column 3 sampled 16 cycles out, then 8 debounce cycles.
        keys[11] = 1'b1;
        wait_pulse(60, lat);
        check("press_lat", lat, 24);
        check("press_code", keycode, KEY_CLEAR);
        step(16);
        check("press_count", pulses, 1);
        check("press_col_held", col, 4'b0111);
        keys[11] = 1'b0;
        step(10); check("rel_col_held", col, 4'b0111);
        step(1);  check("rel_col_scan", col, 4'b1110);

        // Bouncing row 1 in column 0: detected then aborted, scan resumes at column 1 late.
        keys[4] = 1'b1;
        step(3);
        keys[4] = 1'b0;
        step(1);  check("bnc_col_hold", col, 4'b1110);
        step(2);  check("bnc_col_abort", col, 4'b1101);
        for (int i = 0; i < 10; i++) begin
            keys[4] = ~keys[4];
            step(3);
        end
        keys[4] = 1'b0;
        step(20);
        check("bnc_no_pulse", pulses, 1);

        // Rows 1 and 3 together in column 2: lowest row wins, code {01,10}.
        keys[6]  = 1'b1;
        keys[14] = 1'b1;
        wait_pulse(60, lat);
        check("two_seen", lat > 0, 1'b1);
        check("two_code", keycode, 4'd6);
        step(10);
        keys = 16'h0;
        step(20);
        check("two_count", pulses, 2);

        // Release with a 4-cycle low glitch after 5 high cycles.
        keys[11] = 1'b1;
        wait_pulse(60, lat);
        check("glitch_press_seen", lat > 0, 1'b1);
        keys[11] = 1'b0;
        step(5);
        keys[11] = 1'b1;
        step(4);
        keys[11] = 1'b0;
        step(2);  check("glitch_col_r11", col, 4'b0111);
        step(8);  check("glitch_col_r19", col, 4'b0111);
        step(1);  check("glitch_col_r20", col, 4'b1110);
        check("glitch_count", pulses, 3);

        // Fresh press of row 1 / column 1, then a long hold.
        keys[5] = 1'b1;
        wait_pulse(60, lat);
        check("fresh_seen", lat > 0, 1'b1);
        check("fresh_code", keycode, 4'd5);
        check("fresh_count", pulses, 4);
        for (int i = 1; i <= 60; i++) begin
            step(1);
            if (newkey) rep_offs.push_back(i);
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        check("rep_n", rep_offs.size(), 3);
        if (rep_offs.size() == 3) begin
            check("rep_t0", rep_offs[0], 16);
            check("rep_t1", rep_offs[1], 32);
            check("rep_t2", rep_offs[2], 48);
        end
        check("rep_code", keycode, 4'd5);
`else
        check("hold_no_repeat", rep_offs.size(), 0);
`endif
        keys = 16'h0;
        step(20);

        // Asynchronous reset in the middle of a press discards it.
        keys[5] = 1'b1;
        step(6);
        reset = 1'b1;
        #1;
        check("arst_col", col, 4'b1110);
        check("arst_newkey", newkey, 1'b0);
        check("arst_keycode", keycode, 4'h0);
        keys = 16'h0;
        step(3);
        reset = 1'b0;
        base = pulses;
        step(40);
        check("arst_no_pulse", pulses - base, 0);
        check("arst_keycode_kept", keycode, 4'h0);

        check("newkey_single_cycle", dbl_viol, 0);
        check("keycode_only_on_newkey", kc_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
